fifo_drain_tx: RTL and testbench

- Consumer at the read end of the 32x9 scan-testable FIFO.
- Pops 9-bit words through the FIFO's valid/stall interface: FIFO `pout` drives `pin` here; this block's `sout` drives FIFO `sin`.
- Serializes each word as an async frame on `txd`: start bit, 8 data bits LSB first, stop bit. Bit 8 of each word marks end-of-packet and appends an idle gap.
- All state flops sit on a scan chain controlled by `TM`/`SI`/`S0`, matching the FIFO's test access.

---
 rtl/fifo_drain_tx.sv | 168 ++++++++++++++++
 tb/tb_fifo_drain_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_tx.sv
// fifo_drain_tx: pops 9-bit words from the read side of the scan-testable FIFO
// and transmits each payload byte as an async frame (start, 8 data LSB first,
// stop). An end-of-packet word is followed by an idle gap. Every state flop
// belongs to one scan chain: SI -> eop -> shreg -> bitcnt -> baud -> state -> S0.
module fifo_drain_tx #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned GAP_BITS     = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pin,
    input  logic [8:0] din,
    output logic       sout,
    output logic       txd,
    output logic       busy,
    input  logic       TM,
    input  logic       SI,
    output logic       S0
);

    localparam int unsigned W         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned CHAIN_LEN = 16 + W;
    localparam logic [W-1:0] BAUD_LAST = W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]   DATA_LAST = 4'd7;
    localparam logic [3:0]   GAP_LAST  = 4'(GAP_BITS - 1);
    localparam logic         HAS_GAP   = (GAP_BITS > 0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   baud_q,  baud_d;
    logic [3:0]     bitcnt_q, bitcnt_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           eop_q,   eop_d;

    logic                 pop_c;
    logic                 bit_end_c;
    logic [W-1:0]         baud_inc_c;
    logic [CHAIN_LEN-1:0] chain_c;
    logic [CHAIN_LEN-1:0] chain_next_c;
    logic [2:0]           scan_state_c;

    // A pop happens only from IDLE with data available and scan mode off.
    assign pop_c      = (state_q == ST_IDLE) && pin && !TM;
    assign bit_end_c  = (baud_q == BAUD_LAST);
    assign baud_inc_c = baud_q + W'(1);

    // Whole register set viewed as the scan chain, eop nearest SI.
    assign chain_c      = {eop_q, shreg_q, bitcnt_q, baud_q, state_q};
    assign chain_next_c = {SI, chain_c[CHAIN_LEN-1:1]};

    // Next-state logic: functional frame sequencing, overridden by scan shift.
    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        bitcnt_d     = bitcnt_q;
        shreg_d      = shreg_q;
        eop_d        = eop_q;
        scan_state_c = 3'd0;

        case (state_q)
            ST_IDLE: begin
                if (pop_c) begin
                    shreg_d  = din[7:0];
                    eop_d    = din[8];
                    baud_d   = '0;
                    bitcnt_d = 4'd0;
                    state_d  = ST_START;
                end
            end

            ST_START: begin
                baud_d = baud_inc_c;
                if (bit_end_c) begin
                    baud_d  = '0;
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                baud_d = baud_inc_c;
                if (bit_end_c) begin
                    baud_d   = '0;
                    shreg_d  = {1'b0, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == DATA_LAST) begin
                        state_d = ST_STOP;
                    end
                end
            end

            ST_STOP: begin
                baud_d = baud_inc_c;
                if (bit_end_c) begin
                    baud_d = '0;
                    if (eop_q && HAS_GAP) begin
                        bitcnt_d = 4'd0;
                        state_d  = ST_GAP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_GAP: begin
                baud_d = baud_inc_c;
                if (bit_end_c) begin
                    baud_d   = '0;
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == GAP_LAST) begin
                        eop_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end

            // Unused codes (reachable only through scan) recover to IDLE.
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (TM) begin
            {eop_d, shreg_d, bitcnt_d, baud_d, scan_state_c} = chain_next_c;
            state_d = state_e'(scan_state_c);
        end
    end

    // State register; reset wins over scan.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bitcnt_q <= 4'd0;
            shreg_q  <= 8'd0;
            eop_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            eop_q    <= eop_d;
        end
    end

    // Serial line level for the current bit; forced idle-high in scan mode.
    always_comb begin
        txd = 1'b1;
        if (!TM) begin
            case (state_q)
                ST_START: txd = 1'b0;
                ST_DATA:  txd = shreg_q[0];
                default:  txd = 1'b1;
            endcase
        end
    end

    assign sout = !pop_c;
    assign busy = (state_q != ST_IDLE);
    assign S0   = chain_c[0];

endmodule

// File: tb/tb_fifo_drain_tx.sv
// Scoreboard bench for fifo_drain_tx: a queue-based FIFO feeds the DUT, and a
// frame-level model predicts txd/busy per cycle and when pops must occur.
module tb_fifo_drain_tx;

    localparam int unsigned CPB = 4;
    localparam int unsigned GAP = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       pin   = 1'b0;
    logic [8:0] din   = 9'h000;
    logic       TM    = 1'b0;
    logic       SI    = 1'b0;
    logic       sout, txd, busy, S0;

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;

    logic [8:0] src_q[$];     // words sitting in the FIFO
    logic [1:0] exp_q[$];     // expected {txd, busy} per cycle of frames in flight
    int         pop_cyc[$];   // cycle numbers of observed pops
    bit         pop_pending = 1'b0;
    bit         mon_en      = 1'b0;
    bit         hold_pin    = 1'b0;

    fifo_drain_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAP)) dut (
        .clock (clock),
        .reset (reset),
        .pin   (pin),
        .din   (din),
        .sout  (sout),
        .txd   (txd),
        .busy  (busy),
        .TM    (TM),
        .SI    (SI),
        .S0    (S0)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Expected line levels for one word: start, 8 data LSB first, stop, gap if eop.
    function automatic void push_frame(input logic [8:0] w);
        int   nbits;
        logic lvl;
        nbits = 10 + (w[8] ? int'(GAP) : 0);
        for (int k = 0; k < nbits; k++) begin
            if (k == 0)      lvl = 1'b0;
            else if (k <= 8) lvl = w[k-1];
            else             lvl = 1'b1;
            repeat (CPB) exp_q.push_back({lvl, 1'b1});
        end
    endfunction

    task automatic update_inputs();
        pin = (src_q.size() > 0) && !hold_pin;
        din = (src_q.size() > 0) ? src_q[0] : 9'h000;
    endtask

    task automatic tick();
        @(posedge clock);
        if (pop_pending) begin
            src_q.delete(0);
            pop_pending = 1'b0;
        end
        #1;
        update_inputs();
    endtask

    // Monitor: compare every cycle against the frame model; predict pops.
    always @(negedge clock) begin : monitor
        logic [1:0] e;
        if (mon_en) begin
            if (TM) begin
                check("scan_sout", sout, 1);
                check("scan_txd", txd, 1);
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("frame_txd", txd, e[1]);
                check("frame_busy", busy, e[0]);
                check("frame_sout", sout, 1);
            end else begin
                check("idle_txd", txd, 1);
                check("idle_busy", busy, 0);
                check("idle_sout", sout, pin ? 0 : 1);
                if (pin && !reset) begin
                    push_frame(din);
                    pop_pending = 1'b1;
                    pop_cyc.push_back(cycle);
                end
            end
            if (reset) begin
                exp_q.delete();
                pop_pending = 1'b0;
            end
        end
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && n < 10000) begin
            tick();
            n++;
        end
        if (n >= 10000) check({name, "_drain_timeout"}, n, 0);
        tick();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cycle);
        $fatal(1);
    end

    initial begin : main
        logic [17:0] pat;
        int          n;
        int          pushed;

        // Reset, then idle with an empty FIFO
        repeat (3) tick();
        mon_en = 1'b1;
        reset  = 1'b0;
        repeat (20) tick();
        check("idle_pops", pop_cyc.size(), 0);

        // Single word
        src_q.push_back(9'h0A5);
        update_inputs();
        wait_idle("a5");
        check("a5_pops", pop_cyc.size(), 1);

        // Back-to-back words
        pop_cyc.delete();
        src_q.push_back(9'h012);
        src_q.push_back(9'h034);
        update_inputs();
        wait_idle("b2b");
        check("b2b_pops", pop_cyc.size(), 2);
        if (pop_cyc.size() == 2) check("b2b_spacing", pop_cyc[1] - pop_cyc[0], 10 * CPB + 1);

        // End-of-packet word followed by another
        pop_cyc.delete();
        src_q.push_back(9'h1FF);
        src_q.push_back(9'h055);
        update_inputs();
        wait_idle("eop");
        check("eop_pops", pop_cyc.size(), 2);
        if (pop_cyc.size() == 2) check("eop_spacing", pop_cyc[1] - pop_cyc[0], (10 + GAP) * CPB + 1);

        // Reset in the middle of a frame
        pop_cyc.delete();
        src_q.push_back(9'h0C3);
        src_q.push_back(9'h13C);
        update_inputs();
        n = 0;
        while (pop_cyc.size() == 0 && n < 100) begin
            tick();
            n++;
        end
        check("rst_first_pop", pop_cyc.size(), 1);
        repeat (15) tick();
        hold_pin = 1'b1;
        reset    = 1'b1;
        update_inputs();
        tick();
        reset = 1'b0;
        check("rst_txd", txd, 1);
        check("rst_busy", busy, 0);
        check("rst_sout", sout, 1);
        repeat (10) tick();
        check("rst_no_repop", pop_cyc.size(), 1);
        hold_pin = 1'b0;
        update_inputs();
        wait_idle("rst");
        check("rst_resume_pops", pop_cyc.size(), 2);

        // Randomised traffic with random pin stalls
        pop_cyc.delete();
        pushed = 0;
        for (int i = 0; i < 25; i++) begin
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) begin
                src_q.push_back({($urandom % 4) == 0, 8'($urandom)});
                pushed++;
            end
            update_inputs();
            repeat ($urandom_range(5, 80)) begin
                hold_pin = (($urandom % 5) == 0);
                update_inputs();
                tick();
            end
        end
        hold_pin = 1'b0;
        update_inputs();
        wait_idle("rand");
        check("rand_pops", pop_cyc.size(), pushed);

        // Scan shift: pattern in through SI, out on S0 in the same order
        pat = 18'h2D3A1;
        TM  = 1'b1;
        for (int i = 0; i < 18; i++) begin
            SI = pat[17-i];
            tick();
        end
        for (int k = 0; k < 18; k++) begin
            check($sformatf("scan_s0_%0d", k), S0, pat[17-k]);
            SI = 1'b0;
            tick();
        end
        TM = 1'b0;
        check("scan_busy_after", busy, 0);
        tick();

        // Normal operation after scan left the chain at IDLE
        pop_cyc.delete();
        src_q.push_back(9'h0F0);
        update_inputs();
        wait_idle("post_scan");
        check("post_scan_pops", pop_cyc.size(), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
